// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock) with
// valid/ready handshakes, leading-zero blanking and saturate-or-wrap overflow handling.
module bin2bcd_seq #(
    parameter int unsigned WIDTH  = 12,
    parameter int unsigned DIGITS = 4,
    parameter int unsigned SAT    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] out_bcd,
    output logic [DIGITS-1:0]   out_blank,
    output logic                out_ovf,
    output logic                busy
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam int unsigned BcdW = 4 * DIGITS;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [BcdW-1:0]    digits_q, digits_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic [BcdW-1:0]    out_bcd_q, out_bcd_d;
    logic [DIGITS-1:0]  out_blank_q, out_blank_d;
    logic               out_ovf_q, out_ovf_d;

    logic [BcdW-1:0]       adj;
    logic [BcdW+WIDTH-1:0] chain;
    logic [BcdW-1:0]       dig_sh;
    logic [WIDTH-1:0]      shift_sh;
    logic                  carry_out;
    logic [DIGITS-1:0]     blank_sh;
    logic                  zero_above;
    logic                  sat_now;

    // Add-3 adjust on every digit, then shift the whole {digits, binary} chain left by one.
    always_comb begin
        adj = '0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            adj[4*k +: 4] = (digits_q[4*k +: 4] >= 4'd5) ? digits_q[4*k +: 4] + 4'd3
                                                         : digits_q[4*k +: 4];
        end
        chain     = {adj, shift_q} << 1;
        dig_sh    = chain[WIDTH +: BcdW];
        shift_sh  = chain[WIDTH-1:0];
        carry_out = adj[BcdW-1];
    end

    // Digit k is blanked when it and every digit above it are zero; units never blank.
    always_comb begin
        blank_sh   = '0;
        zero_above = 1'b1;
        for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
            zero_above  = zero_above & (dig_sh[4*k +: 4] == 4'd0);
            blank_sh[k] = zero_above;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        digits_d    = digits_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_bcd_d   = out_bcd_q;
        out_blank_d = out_blank_q;
        out_ovf_d   = out_ovf_q;
        sat_now     = 1'b0;
        case (state_q)
            StIdle: begin
                if (in_valid && in_ready) begin
                    shift_d  = in_data;
                    digits_d = '0;
                    ovf_d    = 1'b0;
                    cnt_d    = CntW'(WIDTH);
                    state_d  = StShift;
                end
            end
            StShift: begin
                shift_d  = shift_sh;
                digits_d = dig_sh;
                ovf_d    = ovf_q | carry_out;
                cnt_d    = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d     = StDone;
                    sat_now     = (SAT != 0) && ovf_d;
                    out_valid_d = 1'b1;
                    out_ovf_d   = ovf_d;
                    out_bcd_d   = sat_now ? {DIGITS{4'h9}} : dig_sh;
                    out_blank_d = sat_now ? '0 : blank_sh;
                end
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            shift_q     <= '0;
            digits_q    <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_bcd_q   <= '0;
            out_blank_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            digits_q    <= digits_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_bcd_q   <= out_bcd_d;
            out_blank_q <= out_blank_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign in_ready  = (state_q == StIdle) && !rst;
    assign busy      = (state_q == StShift);
    assign out_valid = out_valid_q;
    assign out_bcd   = out_bcd_q;
    assign out_blank = out_blank_q;
    assign out_ovf   = out_ovf_q;

endmodule
